// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB with a 2-bit saturating counter per entry.
// Lookup at IF is purely combinational from the registered table. Training happens at EX on
// each resolved conditional branch. A saturating counter tallies reported mispredictions.
//
// Ports:
//   clk                    clock, all state updates on the rising edge
//   reset                  asynchronous active-low reset
//   if_pc                  fetch PC to predict (word aligned)
//   branch_estimation      1 = predict taken for if_pc
//   predicted_target       predicted target if taken, else if_pc + 4
//   ex_branch              update strobe: EX holds a resolved conditional branch
//   ex_pc                  PC of the resolving branch
//   branch_taken           actual outcome
//   branch_target_actual   actual branch target
//   branch_prediction_miss estimation differed from outcome
//   mispredict_count       saturating count of updates flagged as mispredicted
module branch_predictor #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      if_pc,
  output logic             branch_estimation,
  output logic [31:0]      predicted_target,
  input  logic             ex_branch,
  input  logic [31:0]      ex_pc,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target_actual,
  input  logic             branch_prediction_miss,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = 32 - IDX_W - 2;

  localparam logic [1:0] CtrWeakNt   = 2'b01;
  localparam logic [1:0] CtrWeakTk   = 2'b10;
  localparam logic [1:0] CtrStrongTk = 2'b11;
  localparam logic [1:0] CtrStrongNt = 2'b00;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [CNT_W-1:0]   count_q;

  // Lookup path
  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;

  always_comb begin
    if_idx            = if_pc[IDX_W+1:2];
    if_tag            = if_pc[31:IDX_W+2];
    if_hit            = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    branch_estimation = if_hit && ctr_q[if_idx][1];
    predicted_target  = branch_estimation ? target_q[if_idx] : (if_pc + 32'd4);
  end

  // Training path
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;
  logic             upd_en;
  logic [1:0]       upd_ctr;
  logic [31:0]      upd_target;
  logic [1:0]       cur_ctr;

  always_comb begin
    ex_idx     = ex_pc[IDX_W+1:2];
    ex_tag     = ex_pc[31:IDX_W+2];
    ex_hit     = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    cur_ctr    = ctr_q[ex_idx];
    // A not-taken branch that misses the table leaves it untouched.
    upd_en     = ex_branch && (ex_hit || branch_taken);
    upd_ctr    = CtrWeakTk;
    upd_target = branch_taken ? branch_target_actual : target_q[ex_idx];
    if (ex_hit) begin
      if (branch_taken) begin
        upd_ctr = (cur_ctr == CtrStrongTk) ? CtrStrongTk : cur_ctr + 2'd1;
      end else begin
        upd_ctr = (cur_ctr == CtrStrongNt) ? CtrStrongNt : cur_ctr - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CtrWeakNt;
      end
    end else if (upd_en) begin
      // Allocation and hit update write the same fields; on a hit tag is rewritten unchanged.
      valid_q[ex_idx]  <= 1'b1;
      tag_q[ex_idx]    <= ex_tag;
      target_q[ex_idx] <= upd_target;
      ctr_q[ex_idx]    <= upd_ctr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (ex_branch && branch_prediction_miss && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign mispredict_count = count_q;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  localparam int unsigned ENTRIES = 16;
  localparam int unsigned CNT_W   = 6;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic [31:0]      if_pc;
  logic             branch_estimation;
  logic [31:0]      predicted_target;
  logic             ex_branch;
  logic [31:0]      ex_pc;
  logic             branch_taken;
  logic [31:0]      branch_target_actual;
  logic             branch_prediction_miss;
  logic [CNT_W-1:0] mispredict_count;

  branch_predictor #(
    .ENTRIES(ENTRIES),
    .CNT_W  (CNT_W)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .if_pc                 (if_pc),
    .branch_estimation     (branch_estimation),
    .predicted_target      (predicted_target),
    .ex_branch             (ex_branch),
    .ex_pc                 (ex_pc),
    .branch_taken          (branch_taken),
    .branch_target_actual  (branch_target_actual),
    .branch_prediction_miss(branch_prediction_miss),
    .mispredict_count      (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: one slot per table index, holding the full owning PC and a confidence 0..3.
  bit          m_valid [ENTRIES];
  int unsigned m_owner [ENTRIES];
  int unsigned m_tgt   [ENTRIES];
  int          m_conf  [ENTRIES];
  int unsigned m_count;

  function automatic int unsigned slot_of(input int unsigned pc);
    return (pc / 4) % ENTRIES;
  endfunction

  function automatic bit same_line(input int unsigned a, input int unsigned b);
    return (a / (4 * ENTRIES)) == (b / (4 * ENTRIES));
  endfunction

  function automatic bit m_hit(input int unsigned pc);
    return m_valid[slot_of(pc)] && same_line(m_owner[slot_of(pc)], pc);
  endfunction

  function automatic bit m_est(input int unsigned pc);
    return m_hit(pc) && (m_conf[slot_of(pc)] >= 2);
  endfunction

  function automatic int unsigned m_target(input int unsigned pc);
    return m_est(pc) ? m_tgt[slot_of(pc)] : pc + 32'd4;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < int'(ENTRIES); i++) begin
      m_valid[i] = 1'b0;
      m_conf[i]  = 1;
    end
    m_count = 0;
  endtask

  task automatic m_train(input int unsigned pc, input bit tk, input int unsigned tgt,
                         input bit miss);
    int unsigned s;
    s = slot_of(pc);
    if (tk) begin
      if (m_hit(pc)) begin
        m_conf[s] = (m_conf[s] + 1 > 3) ? 3 : m_conf[s] + 1;
      end else begin
        m_valid[s] = 1'b1;
        m_owner[s] = pc;
        m_conf[s]  = 2;
      end
      m_tgt[s] = tgt;
    end else if (m_hit(pc)) begin
      m_conf[s] = (m_conf[s] - 1 < 0) ? 0 : m_conf[s] - 1;
    end
    if (miss && m_count < CNT_MAX) m_count++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_est"}, {31'd0, branch_estimation}, {31'd0, m_est(if_pc)});
    check({tag, "_tgt"}, predicted_target, m_target(if_pc));
    check({tag, "_cnt"}, {{(32 - CNT_W){1'b0}}, mispredict_count}, m_count);
  endtask

  // One clock cycle: drive, check lookup against model, then clock the update into the model.
  task automatic step(input logic [31:0] lpc, input bit exb, input logic [31:0] epc,
                      input bit tk, input logic [31:0] tgt, input bit miss, input string tag);
    @(negedge clk);
    if_pc                  = lpc;
    ex_branch              = exb;
    ex_pc                  = epc;
    branch_taken           = tk;
    branch_target_actual   = tgt;
    branch_prediction_miss = miss;
    #1;
    check_model(tag);
    @(posedge clk);
    if (exb) m_train(epc, tk, tgt, miss);
  endtask

  task automatic look(input logic [31:0] lpc, input bit e_est, input logic [31:0] e_tgt,
                      input string tag);
    @(negedge clk);
    if_pc     = lpc;
    ex_branch = 1'b0;
    #1;
    check({tag, "_est"}, {31'd0, branch_estimation}, {31'd0, e_est});
    check({tag, "_tgt"}, predicted_target, e_tgt);
  endtask

  initial begin
    reset                  = 1'b0;
    if_pc                  = 32'h100;
    ex_branch              = 1'b0;
    ex_pc                  = '0;
    branch_taken           = 1'b0;
    branch_target_actual   = '0;
    branch_prediction_miss = 1'b0;
    m_reset();
    #12;
    check("reset_est", {31'd0, branch_estimation}, 32'd0);
    check("reset_tgt", predicted_target, 32'h104);
    check("reset_cnt", {{(32 - CNT_W){1'b0}}, mispredict_count}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Allocation
    step(32'h100, 1'b1, 32'h100, 1'b1, 32'h140, 1'b1, "alloc");
    look(32'h100, 1'b1, 32'h140, "after_alloc");
    check("cnt_one", {{(32 - CNT_W){1'b0}}, mispredict_count}, 32'd1);

    // Saturate up, then walk down through the taken/not-taken boundary
    for (int i = 0; i < 3; i++) step(32'h100, 1'b1, 32'h100, 1'b1, 32'h140, 1'b0, "sat_up");
    step(32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, "dec_st");
    look(32'h100, 1'b1, 32'h140, "ctr_wt");
    step(32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, "dec_wt");
    look(32'h100, 1'b0, 32'h104, "ctr_wnt");

    // Aliasing on index 0
    look(32'h140, 1'b0, 32'h144, "alias_miss");
    step(32'h140, 1'b1, 32'h140, 1'b1, 32'h200, 1'b1, "alias_alloc");
    look(32'h100, 1'b0, 32'h104, "evicted");
    look(32'h140, 1'b1, 32'h200, "alias_hit");

    // Same-cycle lookup/update returns pre-update state
    step(32'h100, 1'b1, 32'h100, 1'b1, 32'h140, 1'b1, "realloc");
    @(negedge clk);
    if_pc                  = 32'h100;
    ex_branch              = 1'b1;
    ex_pc                  = 32'h100;
    branch_taken           = 1'b0;
    branch_prediction_miss = 1'b1;
    #1;
    check("no_bypass_est", {31'd0, branch_estimation}, 32'd1);
    check("no_bypass_tgt", predicted_target, 32'h140);
    @(posedge clk);
    m_train(32'h100, 1'b0, 32'h0, 1'b1);
    look(32'h100, 1'b0, 32'h104, "after_same_cycle");

    // Wrap of fall-through target
    look(32'hFFFF_FFFC, 1'b0, 32'h0, "pc_wrap");

    // Strobe low is ignored
    step(32'h180, 1'b0, 32'h180, 1'b1, 32'h400, 1'b1, "ignored");
    look(32'h180, 1'b0, 32'h184, "ignored_look");

    // Counter saturation
    for (int i = 0; i < int'(CNT_MAX) + 2; i++) begin
      step(32'h300, 1'b1, 32'h300, 1'b0, 32'h0, 1'b1, "cnt_sat");
    end
    step(32'h300, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, "cnt_hold");
    check("cnt_max", {{(32 - CNT_W){1'b0}}, mispredict_count}, CNT_MAX);

    // Async reset mid-cycle while an update is presented
    step(32'h100, 1'b1, 32'h100, 1'b1, 32'h140, 1'b0, "pre_reset_alloc");
    look(32'h100, 1'b1, 32'h140, "pre_reset");
    ex_branch    = 1'b1;
    ex_pc        = 32'h100;
    branch_taken = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    m_reset();
    check("areset_est", {31'd0, branch_estimation}, 32'd0);
    check("areset_tgt", predicted_target, 32'h104);
    check("areset_cnt", {{(32 - CNT_W){1'b0}}, mispredict_count}, 32'd0);
    @(posedge clk);
    #1;
    check("reset_wins_est", {31'd0, branch_estimation}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Randomized training against the model, PCs drawn from a small pool to force hits/aliases
    for (int i = 0; i < 400; i++) begin
      logic [31:0] lp, ep;
      lp = {$urandom_range(0, 7), 2'b00} << 4;
      ep = {$urandom_range(0, 7), 2'b00} << 4;
      if ($urandom_range(0, 3) == 0) lp = ep;
      step(lp, 1'($urandom_range(0, 3) != 0), ep, 1'($urandom), $urandom & 32'hFFFF_FFFC,
           1'($urandom), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
